screen_sequencer: RTL and testbench

- Frame-synchronous game flow controller for the VGA screen pipeline. Drives the `state` selector used by draw_background and the rgb mux (IDLE / WAIT / GAME / SCORE).
- Takes click, UART and stop events from click_ctl, the UART link and the mouse path. Latches them and applies transitions only at a frame boundary (rising edge of vblnk), so the screen never tears.
- Generates the game countdown (BCD seconds) shown by the char ROMs and a one-cycle state-entry strobe for downstream blocks.

---
 rtl/screen_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_screen_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_sequencer.sv
// Frame-synchronous game flow controller: latches click/UART/stop events and
// switches IDLE/WAIT/GAME/SCORE only on a vblnk rising edge, with a BCD countdown.
module screen_sequencer #(
  parameter int unsigned FPS            = 60,
  parameter int unsigned GAME_SECONDS   = 30,
  parameter int unsigned WAIT_TIMEOUT_S = 10,
  parameter int unsigned SCORE_HOLD_S   = 5
) (
  input  logic       pclk_i,
  input  logic       rst_ni,
  input  logic       vblnk_i,
  input  logic       rect_clicked_play_i,
  input  logic       uart_start_i,
  input  logic       mouse_clicked_stop_i,
  output logic [1:0] state_o,
  output logic       state_entry_o,
  output logic       frame_tick_o,
  output logic [7:0] time_left_bcd_o,
  output logic       tx_ready_o,
  output logic       game_active_o
);

  localparam int unsigned FCW = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int unsigned SCW = 7;
  localparam int unsigned TW  = 8;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FPS - 1);
  localparam logic [SCW-1:0] SEC_MAX    = {SCW{1'b1}};
  localparam logic [SCW-1:0] WAIT_SEC   = SCW'(WAIT_TIMEOUT_S);
  localparam logic [SCW-1:0] HOLD_SEC   = SCW'(SCORE_HOLD_S);
  localparam logic [TW-1:0]  GAME_BCD   = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAME  = 2'd2,
    ST_SCORE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           vblnk_q, play_in_q, start_in_q, stop_in_q;
  logic           play_flag_q, play_flag_d;
  logic           start_flag_q, start_flag_d;
  logic           stop_flag_q, stop_flag_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [SCW-1:0] sec_cnt_q, sec_cnt_d;
  logic [TW-1:0]  time_q, time_d;
  logic           entry_q, entry_d;
  logic           tick_q, tick_d;
  logic           tx_q, tx_d;
  logic           act_q, act_d;

  logic           frame_edge, play_edge, start_edge, stop_edge;
  logic           hold_done, play_ok;
  logic           play_pend, start_pend, stop_pend;
  logic           sec_wrap;
  logic [FCW-1:0] frame_inc;
  logic [SCW-1:0] sec_inc;
  logic [TW-1:0]  time_dec;

  // Two-digit BCD decrement, saturating at 00.
  function automatic logic [TW-1:0] bcd_dec(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    r = v;
    if (v == 8'h00) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  assign frame_edge = vblnk_i & ~vblnk_q;
  assign play_edge  = rect_clicked_play_i & ~play_in_q;
  assign start_edge = uart_start_i & ~start_in_q;
  assign stop_edge  = mouse_clicked_stop_i & ~stop_in_q;

  // An edge only counts when the current state can act on it.
  assign hold_done  = (sec_cnt_q >= HOLD_SEC);
  assign play_ok    = (state_q == ST_IDLE) | ((state_q == ST_SCORE) & hold_done);
  assign play_pend  = play_flag_q | (play_edge & play_ok);
  assign start_pend = start_flag_q | (start_edge & (state_q == ST_WAIT));
  assign stop_pend  = stop_flag_q | (stop_edge & (state_q == ST_GAME));

  assign sec_wrap  = (frame_cnt_q == FRAME_LAST);
  assign frame_inc = sec_wrap ? '0 : frame_cnt_q + FCW'(1);
  assign sec_inc   = (sec_wrap && sec_cnt_q != SEC_MAX) ? sec_cnt_q + SCW'(1) : sec_cnt_q;
  assign time_dec  = sec_wrap ? bcd_dec(time_q) : time_q;

  always_comb begin
    state_d      = state_q;
    play_flag_d  = play_pend;
    start_flag_d = start_pend;
    stop_flag_d  = stop_pend;
    frame_cnt_d  = frame_cnt_q;
    sec_cnt_d    = sec_cnt_q;
    time_d       = time_q;
    entry_d      = 1'b0;
    tick_d       = frame_edge;

    if (frame_edge) begin
      frame_cnt_d = frame_inc;
      sec_cnt_d   = sec_inc;
      unique case (state_q)
        ST_IDLE: begin
          if (play_pend) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (start_pend)             state_d = ST_GAME;
          else if (sec_inc >= WAIT_SEC) state_d = ST_IDLE;
        end
        ST_GAME: begin
          time_d = time_dec;
          if (stop_pend || time_dec == 8'h00) state_d = ST_SCORE;
        end
        ST_SCORE: begin
          if (play_pend) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Every transition restarts the per-state timing and drops stale events.
    if (state_d != state_q) begin
      entry_d      = 1'b1;
      play_flag_d  = 1'b0;
      start_flag_d = 1'b0;
      stop_flag_d  = 1'b0;
      frame_cnt_d  = '0;
      sec_cnt_d    = '0;
      time_d       = (state_d == ST_GAME) ? GAME_BCD : 8'h00;
    end

    tx_d  = (state_d == ST_WAIT);
    act_d = (state_d == ST_GAME);
  end

  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      vblnk_q      <= 1'b0;
      play_in_q    <= 1'b0;
      start_in_q   <= 1'b0;
      stop_in_q    <= 1'b0;
      play_flag_q  <= 1'b0;
      start_flag_q <= 1'b0;
      stop_flag_q  <= 1'b0;
      frame_cnt_q  <= '0;
      sec_cnt_q    <= '0;
      time_q       <= 8'h00;
      entry_q      <= 1'b0;
      tick_q       <= 1'b0;
      tx_q         <= 1'b0;
      act_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vblnk_q      <= vblnk_i;
      play_in_q    <= rect_clicked_play_i;
      start_in_q   <= uart_start_i;
      stop_in_q    <= mouse_clicked_stop_i;
      play_flag_q  <= play_flag_d;
      start_flag_q <= start_flag_d;
      stop_flag_q  <= stop_flag_d;
      frame_cnt_q  <= frame_cnt_d;
      sec_cnt_q    <= sec_cnt_d;
      time_q       <= time_d;
      entry_q      <= entry_d;
      tick_q       <= tick_d;
      tx_q         <= tx_d;
      act_q        <= act_d;
    end
  end

  assign state_o         = state_q;
  assign state_entry_o   = entry_q;
  assign frame_tick_o    = tick_q;
  assign time_left_bcd_o = time_q;
  assign tx_ready_o      = tx_q;
  assign game_active_o   = act_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: frame table with hand-derived expectations,
// directed async-reset sequence and random stimulus against a frame-count model.
module tb_screen_sequencer;

  localparam int FPS    = 4;
  localparam int GSEC   = 3;
  localparam int WSEC   = 2;
  localparam int HSEC   = 1;

  logic       pclk_i = 1'b0;
  logic       rst_ni;
  logic       vblnk_i, rect_clicked_play_i, uart_start_i, mouse_clicked_stop_i;
  logic [1:0] state_o;
  logic       state_entry_o, frame_tick_o, tx_ready_o, game_active_o;
  logic [7:0] time_left_bcd_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  screen_sequencer #(
    .FPS(FPS), .GAME_SECONDS(GSEC), .WAIT_TIMEOUT_S(WSEC), .SCORE_HOLD_S(HSEC)
  ) dut (
    .pclk_i(pclk_i), .rst_ni(rst_ni), .vblnk_i(vblnk_i),
    .rect_clicked_play_i(rect_clicked_play_i), .uart_start_i(uart_start_i),
    .mouse_clicked_stop_i(mouse_clicked_stop_i), .state_o(state_o),
    .state_entry_o(state_entry_o), .frame_tick_o(frame_tick_o),
    .time_left_bcd_o(time_left_bcd_o), .tx_ready_o(tx_ready_o),
    .game_active_o(game_active_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: state plus number of frame edges seen since entering it.
  int   m_state, m_frames;
  bit   m_v, m_p, m_u, m_s;
  bit   m_playf, m_startf, m_stopf;
  bit   m_entry, m_tick;
  logic [7:0] m_time;

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_frames = 0;
    m_v = 0; m_p = 0; m_u = 0; m_s = 0;
    m_playf = 0; m_startf = 0; m_stopf = 0;
    m_entry = 0; m_tick = 0; m_time = 8'h00;
  endtask

  task automatic model_step(input bit v, input bit p, input bit u, input bit s);
    bit fe, pe, ue, se;
    int nxt, left;
    fe = v && !m_v; pe = p && !m_p; ue = u && !m_u; se = s && !m_s;
    m_v = v; m_p = p; m_u = u; m_s = s;
    if (pe && (m_state == 0 || (m_state == 3 && m_frames >= FPS * HSEC))) m_playf = 1;
    if (ue && m_state == 1) m_startf = 1;
    if (se && m_state == 2) m_stopf = 1;
    m_tick  = fe;
    m_entry = 0;
    if (fe) begin
      m_frames++;
      nxt = m_state;
      case (m_state)
        0: if (m_playf) nxt = 1;
        1: begin
          if (m_startf) nxt = 2;
          else if (m_frames == FPS * WSEC) nxt = 0;
        end
        2: begin
          left = GSEC - m_frames / FPS;
          if (left < 0) left = 0;
          m_time = to_bcd(left);
          if (m_stopf || left == 0) nxt = 3;
        end
        default: if (m_playf) nxt = 0;
      endcase
      if (nxt != m_state) begin
        m_state = nxt; m_frames = 0; m_entry = 1;
        m_playf = 0; m_startf = 0; m_stopf = 0;
        m_time = (nxt == 2) ? to_bcd(GSEC) : 8'h00;
      end
    end
  endtask

  function automatic logic [15:0] pack(input logic [1:0] st, input logic en, input logic tk,
                                       input logic [7:0] tm, input logic tx, input logic ac);
    return {2'b00, st, en, tk, tm, tx, ac};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got {st,entry,tick,time,tx,act}=%h expected %h",
               name, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_out();
    return pack(state_o, state_entry_o, frame_tick_o, time_left_bcd_o, tx_ready_o, game_active_o);
  endfunction

  // One clock: drive inputs, advance model, sample outputs 1ns after the edge.
  task automatic tick(input bit v, input bit p, input bit u, input bit s);
    vblnk_i = v; rect_clicked_play_i = p; uart_start_i = u; mouse_clicked_stop_i = s;
    if (!rst_ni) model_reset();
    else model_step(v, p, u, s);
    @(posedge pclk_i);
    #1;
    cyc++;
    check("model", dut_out(),
          pack(2'(m_state), m_entry, m_tick, m_time, m_state == 1, m_state == 2));
  endtask

  typedef struct {
    int         p_off, u_off, s_off;
    bit         chk;
    logic [1:0] st;
    bit         entry;
    logic [7:0] tm;
  } frame_rec_t;

  // 100-cycle frame, vblnk high for the first 10; events are 3-cycle pulses.
  task automatic frame(input frame_rec_t r, input int len);
    for (int i = 0; i < len; i++) begin
      tick(i < 10,
           r.p_off >= 0 && i >= r.p_off && i < r.p_off + 3,
           r.u_off >= 0 && i >= r.u_off && i < r.u_off + 3,
           r.s_off >= 0 && i >= r.s_off && i < r.s_off + 3);
      if (i == 0 && r.chk)
        check("table", dut_out(), pack(r.st, r.entry, 1'b1, r.tm, r.st == 2'd1, r.st == 2'd2));
    end
  endtask

  function automatic frame_rec_t fr(input int p, input int u, input int s,
                                    input logic [1:0] st, input bit en, input logic [7:0] tm);
    frame_rec_t r;
    r.p_off = p; r.u_off = u; r.s_off = s; r.chk = 1;
    r.st = st; r.entry = en; r.tm = tm;
    return r;
  endfunction

  frame_rec_t tbl[$];
  frame_rec_t nochk;

  initial begin
    // Expected state after each frame's leading edge; events act at the next edge.
    tbl.push_back(fr(30, -1, -1, 0, 0, 8'h00));             // IDLE, click
    tbl.push_back(fr(-1, -1, -1, 1, 1, 8'h00));             // WAIT entered
    for (int k = 0; k < 7; k++) tbl.push_back(fr(-1, -1, -1, 1, 0, 8'h00));
    tbl.push_back(fr(30, -1, -1, 0, 1, 8'h00));             // timeout after 8 edges
    tbl.push_back(fr(-1, 10, -1, 1, 1, 8'h00));             // WAIT, uart_start
    tbl.push_back(fr(-1, -1, -1, 2, 1, 8'h03));             // GAME 03
    for (int k = 0; k < 3; k++) tbl.push_back(fr(-1, -1, -1, 2, 0, 8'h03));
    for (int k = 0; k < 4; k++) tbl.push_back(fr(-1, -1, -1, 2, 0, 8'h02));
    for (int k = 0; k < 4; k++) tbl.push_back(fr(-1, -1, -1, 2, 0, 8'h01));
    tbl.push_back(fr(30, -1, -1, 3, 1, 8'h00));             // countdown done -> SCORE
    tbl.push_back(fr(30, -1, -1, 3, 0, 8'h00));             // click during hold
    tbl.push_back(fr(-1, -1, -1, 3, 0, 8'h00));
    tbl.push_back(fr(-1, -1, -1, 3, 0, 8'h00));
    tbl.push_back(fr(30, -1, -1, 3, 0, 8'h00));             // hold expired, click
    tbl.push_back(fr(30, -1, -1, 0, 1, 8'h00));             // IDLE, click
    tbl.push_back(fr(-1, -1, -1, 1, 1, 8'h00));             // WAIT
    for (int k = 0; k < 6; k++) tbl.push_back(fr(-1, -1, -1, 1, 0, 8'h00));
    tbl.push_back(fr(-1, 50, -1, 1, 0, 8'h00));             // start lands on timeout edge
    tbl.push_back(fr(-1, -1, 40, 2, 1, 8'h03));             // GAME wins, stop click
    tbl.push_back(fr(30, -1, -1, 3, 1, 8'h00));             // SCORE, click ignored
    tbl.push_back(fr(-1, -1, -1, 3, 0, 8'h00));
    tbl.push_back(fr(-1, -1, -1, 3, 0, 8'h00));
    tbl.push_back(fr(30, -1, -1, 3, 0, 8'h00));             // still in hold, ignored
    tbl.push_back(fr(30, -1, -1, 3, 0, 8'h00));             // hold expired, click
    tbl.push_back(fr(-1, -1, 40, 0, 1, 8'h00));             // IDLE, stop click
    tbl.push_back(fr(-1, -1, -1, 0, 0, 8'h00));             // no transition
    nochk = fr(-1, -1, -1, 0, 0, 8'h00);
    nochk.chk = 0;

    // Reset held while inputs toggle.
    rst_ni = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) tick(i[0], i[1], i[2], ~i[0]);
    check("reset_state", dut_out(), 16'h0000);
    rst_ni = 1'b1;
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 0);
    check("idle_after_reset", dut_out(), 16'h0000);

    foreach (tbl[i]) frame(tbl[i], 100);

    // Async reset mid-GAME with 02 left.
    frame(fr(30, -1, -1, 0, 0, 8'h00), 100);
    frame(fr(-1, 10, -1, 1, 1, 8'h00), 100);
    for (int k = 0; k < 4; k++) frame(nochk, 100);
    frame(fr(-1, -1, -1, 2, 0, 8'h02), 50);
    #1 rst_ni = 1'b0;
    #1 check("async_reset", dut_out(), 16'h0000);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst_ni = 1'b1;
    frame(fr(-1, -1, 40, 0, 0, 8'h00), 100);
    frame(fr(-1, -1, -1, 0, 0, 8'h00), 100);

    // Random frames and event toggles, with one random reset.
    begin
      bit p = 0, u = 0, s = 0;
      int rst_at = $urandom_range(20, 60);
      for (int f = 0; f < 90; f++) begin
        int len = $urandom_range(20, 70);
        int hi  = $urandom_range(1, 8);
        if (f == rst_at) begin
          rst_ni = 1'b0;
          tick($urandom_range(0, 1), p, u, s);
          tick(0, p, u, s);
          rst_ni = 1'b1;
        end
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 19) == 0) p = ~p;
          if ($urandom_range(0, 29) == 0) u = ~u;
          if ($urandom_range(0, 39) == 0) s = ~s;
          tick(i < hi, p, u, s);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
